// File: rtl/clockdiv_pkg.sv
// Shared types and constants for the programmable clock divider.
// The half-period helpers are used by the per-channel divider and its wrapper.
package clockdiv_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int HALF_1HZ  = 25_000_000;

    typedef logic [CNT_W_DEF-1:0] half_t;

    // A zero half-period would never toggle, so treat it as the fastest rate.
    function automatic half_t clamp_half(input half_t h);
        return (h == '0) ? half_t'(1) : h;
    endfunction

endpackage

// File: rtl/clockdiv_chan.sv
// One divider channel: half-period counter, oclk/otick, and a pending reload
// that takes effect only on a toggle edge (or at once when disabled).
module clockdiv_chan
    import clockdiv_pkg::*;
#(
    parameter int               CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(HALF_1HZ)
) (
    input  logic             iclk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_half,
    output logic             oclk,
    output logic             otick
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_valid_q, pend_valid_d;
    logic             oclk_q, oclk_d;
    logic             otick_q, otick_d;
    logic             apply;

    always_comb begin
        count_d      = count_q;
        half_d       = half_q;
        pend_half_d  = pend_half_q;
        pend_valid_d = pend_valid_q;
        oclk_d       = oclk_q;
        otick_d      = 1'b0;
        apply        = 1'b0;

        if (en) begin
            // >= rather than == so a count left above a shortened half recovers
            if (count_q >= half_q - CNT_W'(1)) begin
                count_d = '0;
                oclk_d  = ~oclk_q;
                otick_d = ~oclk_q;
                apply   = pend_valid_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pend_valid_q) begin
            count_d = '0;
            apply   = 1'b1;
        end

        if (apply) begin
            half_d       = pend_half_q;
            pend_valid_d = 1'b0;
        end

        // A load arriving on an apply edge becomes the next pending value
        if (ld) begin
            pend_half_d  = CNT_W'(clamp_half(half_t'(ld_half)));
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge iclk) begin
        if (rst) begin
            count_q      <= '0;
            half_q       <= DEFAULT_HALF;
            pend_half_q  <= DEFAULT_HALF;
            pend_valid_q <= 1'b0;
            oclk_q       <= 1'b0;
            otick_q      <= 1'b0;
        end else begin
            count_q      <= count_d;
            half_q       <= half_d;
            pend_half_q  <= pend_half_d;
            pend_valid_q <= pend_valid_d;
            oclk_q       <= oclk_d;
            otick_q      <= otick_d;
        end
    end

    assign oclk  = oclk_q;
    assign otick = otick_q;

endmodule

// File: rtl/prog_clockdiv.sv
// Multi-channel programmable clock divider: decodes the shared load port into
// per-channel strobes and instantiates one clockdiv_chan per output clock.
module prog_clockdiv
    import clockdiv_pkg::*;
#(
    parameter int               NUM_CH       = 2,
    parameter int               CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(HALF_1HZ),
    localparam int              CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              iclk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              ld,
    input  logic [CH_W-1:0]   ld_ch,
    input  logic [CNT_W-1:0]  ld_half,
    output logic [NUM_CH-1:0] oclk,
    output logic [NUM_CH-1:0] otick
);

    logic [NUM_CH-1:0] ld_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel indices match no channel and are dropped
        assign ld_sel[i] = ld && (int'(ld_ch) == i);

        clockdiv_chan #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .iclk    (iclk),
            .rst     (rst),
            .en      (en[i]),
            .ld      (ld_sel[i]),
            .ld_half (ld_half),
            .oclk    (oclk[i]),
            .otick   (otick[i])
        );
    end

endmodule
